// File: rtl/pulpino_boot_ctrl_if.sv
// pulpino_boot_ctrl_if: host requests, PIO heartbeat and PULPino configuration conduit for the boot sequencer
// slave modport: the sequencer view (requests/PIO in, core controls and status out).
// master modport: the host/system view (drives requests/PIO, observes core controls and status).
interface pulpino_boot_ctrl_if;
    logic        master_reset_i;
    logic        halt_req_i;
    logic        boot_sel_i;
    logic        cg_en_i;
    logic [31:0] pio_out_i;
    logic        core_rst_n_o;
    logic        fetch_enable_o;
    logic [31:0] boot_addr_o;
    logic        clock_gating_o;
    logic        testmode_o;
    logic [1:0]  state_o;
    logic [7:0]  restart_cnt_o;
    logic        wdt_trip_o;
    modport slave (
        input  master_reset_i, halt_req_i, boot_sel_i, cg_en_i, pio_out_i,
        output core_rst_n_o, fetch_enable_o, boot_addr_o, clock_gating_o, testmode_o,
               state_o, restart_cnt_o, wdt_trip_o
    );
    modport master (
        output master_reset_i, halt_req_i, boot_sel_i, cg_en_i, pio_out_i,
        input  core_rst_n_o, fetch_enable_o, boot_addr_o, clock_gating_o, testmode_o,
               state_o, restart_cnt_o, wdt_trip_o
    );
endinterface

// File: rtl/pulpino_boot_ctrl.sv
// pulpino_boot_ctrl: boot and run-time sequencer releasing, watching and re-booting the PULPino core
// clk_clk: system clock. reset_reset_n: asynchronous active-low reset.
// bus (pulpino_boot_ctrl_if.slave): master_reset_i/halt_req_i requests, boot_sel_i, cg_en_i, pio_out_i heartbeat;
//   core_rst_n_o, fetch_enable_o, boot_addr_o, clock_gating_o, testmode_o, state_o, restart_cnt_o, wdt_trip_o.
// Build option PULPINO_BOOT_WDT_EN adds the heartbeat watchdog; without it wdt_trip_o is 0 and pio_out_i is ignored.
module pulpino_boot_ctrl #(
    parameter logic [31:0] BOOT_ADDR_ROM = 32'h0000_8000,
    parameter logic [31:0] BOOT_ADDR_ALT = 32'h0000_0000,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned FETCH_DLY     = 4,
    parameter int unsigned DRAIN_CYCLES  = 8,
    parameter logic [31:0] WDT_CYCLES    = 32'd1000000,
    parameter int unsigned HB_BIT        = 0
) (
    input logic                clk_clk,
    input logic                reset_reset_n,
    pulpino_boot_ctrl_if.slave bus
);
    localparam logic [1:0] SETUP = 2'd0, RELEASE = 2'd1, RUN = 2'd2, HALT = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] boot_addr_q, boot_addr_d;
    logic [7:0]  restart_cnt_q, restart_cnt_d;
    logic        init_q, core_rst_n_q, fetch_enable_q, clock_gating_q;
    logic        hold, timeout, reboot, unused_cfg;
    assign hold       = bus.master_reset_i | bus.halt_req_i;
    assign reboot     = state_q == HALT && state_d == SETUP;
    assign unused_cfg = ^{bus.pio_out_i, WDT_CYCLES, 32'(HB_BIT)};
    // The first edge after reset acts as the SETUP entry edge, so it loads the boot address and does not count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        case (state_q)
            SETUP: begin
                if (init_q || hold) cnt_d = '0;
                else if (cnt_q == RST_CYCLES - 1) state_d = RELEASE;
            end
            RELEASE: begin
                if (bus.master_reset_i) state_d = HALT;
                else if (cnt_q == FETCH_DLY - 1) state_d = RUN;
            end
            RUN: if (hold || timeout) state_d = HALT;
            default: begin
                if (cnt_q == DRAIN_CYCLES - 1) begin
                    cnt_d = cnt_q;
                    if (!hold) state_d = SETUP;
                end
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end
    assign boot_addr_d   = (init_q || reboot) ? (bus.boot_sel_i ? BOOT_ADDR_ALT : BOOT_ADDR_ROM) : boot_addr_q;
    assign restart_cnt_d = (reboot && restart_cnt_q != 8'hFF) ? restart_cnt_q + 8'd1 : restart_cnt_q;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= SETUP;
            cnt_q          <= '0;
            init_q         <= 1'b1;
            boot_addr_q    <= BOOT_ADDR_ROM;
            restart_cnt_q  <= '0;
            core_rst_n_q   <= 1'b0;
            fetch_enable_q <= 1'b0;
            clock_gating_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            init_q         <= 1'b0;
            boot_addr_q    <= boot_addr_d;
            restart_cnt_q  <= restart_cnt_d;
            core_rst_n_q   <= state_d != SETUP;
            fetch_enable_q <= state_d == RUN;
            clock_gating_q <= state_d == RUN && bus.cg_en_i;
        end
    end
`ifdef PULPINO_BOOT_WDT_EN
    logic        hb_q, hb_edge, wdt_trip_q;
    logic [31:0] wdt_q;
    assign hb_edge = bus.pio_out_i[HB_BIT] ^ hb_q;
    // Trips on the edge where the count would become WDT_CYCLES-1; a heartbeat edge on that cycle cancels it.
    assign timeout = state_q == RUN && !hb_edge && wdt_q == WDT_CYCLES - 32'd2;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hb_q       <= 1'b0;
            wdt_q      <= '0;
            wdt_trip_q <= 1'b0;
        end else begin
            hb_q       <= bus.pio_out_i[HB_BIT];
            wdt_q      <= state_q != RUN ? (state_d == RUN ? '0 : wdt_q) : (hb_edge ? '0 : wdt_q + 32'd1);
            wdt_trip_q <= timeout && !hold;
        end
    end
    assign bus.wdt_trip_o = wdt_trip_q;
`else
    assign timeout        = 1'b0;
    assign bus.wdt_trip_o = 1'b0;
`endif
    assign bus.state_o        = state_q;
    assign bus.core_rst_n_o   = core_rst_n_q;
    assign bus.fetch_enable_o = fetch_enable_q;
    assign bus.boot_addr_o    = boot_addr_q;
    assign bus.clock_gating_o = clock_gating_q;
    assign bus.testmode_o     = 1'b0;
    assign bus.restart_cnt_o  = restart_cnt_q;
endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// tb_pulpino_boot_ctrl: directed bench with an edge-timed reference model of the boot sequencer
module tb_pulpino_boot_ctrl;
    localparam int unsigned RST = 16, FDL = 4, DRN = 8, WDT = 100, HB = 3;
    logic clk = 1'b0, rst_n = 1'b1;
    int n_chk = 0, n_fail = 0;
    int t, t_in, wd_ref, m_rc;
    logic [1:0] m_st;
    logic [31:0] m_boot;
    bit m_trip, m_cg, m_fresh, hb_run;
`ifdef PULPINO_BOOT_WDT_EN
    bit m_hbp;
    int t_hb = 0;
`endif
    always #5 clk = ~clk;
    pulpino_boot_ctrl_if bus();
    pulpino_boot_ctrl #(.RST_CYCLES(RST), .FETCH_DLY(FDL), .DRAIN_CYCLES(DRN), .WDT_CYCLES(32'd100), .HB_BIT(HB))
        dut (.clk_clk(clk), .reset_reset_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, t);
        end
    endtask

    task automatic wait_edge(input int n);
        while (t < n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int k = 0;
        while (bus.state_o !== s && k < budget) begin @(posedge clk); #1; k++; end
        chk("wait_state", {30'd0, bus.state_o}, {30'd0, s});
    endtask

    task automatic m_reset();
        m_st = 2'd0; m_boot = 32'h8000; m_rc = 0; m_trip = 0; m_cg = 0; m_fresh = 1;
        t = -1; t_in = 0; wd_ref = 0;
`ifdef PULPINO_BOOT_WDT_EN
        m_hbp = 0;
`endif
    endtask

    // Reference model: tracks the edge a phase was entered and derives transitions from elapsed edges.
    initial begin
        logic [1:0] nx;
        bit mr, hold;
`ifdef PULPINO_BOOT_WDT_EN
        bit hb_ev;
`endif
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else begin
                t++;
                mr = bus.master_reset_i;
                hold = mr | bus.halt_req_i;
`ifdef PULPINO_BOOT_WDT_EN
                hb_ev = bus.pio_out_i[HB] != m_hbp;
                m_hbp = bus.pio_out_i[HB];
`endif
                m_trip = 0;
                nx = m_st;
                if (m_fresh) begin
                    m_fresh = 0; t_in = t; m_boot = bus.boot_sel_i ? 32'h0 : 32'h8000;
                end else if (m_st == 2'd0) begin
                    if (hold) t_in = t;
                    else if (t - t_in == RST) nx = 2'd1;
                end else if (m_st == 2'd1) begin
                    if (mr) nx = 2'd3;
                    else if (t - t_in == FDL) nx = 2'd2;
                end else if (m_st == 2'd2) begin
                    if (hold) nx = 2'd3;
`ifdef PULPINO_BOOT_WDT_EN
                    else if (hb_ev) wd_ref = t;
                    else if (t - wd_ref == WDT - 1) begin nx = 2'd3; m_trip = 1; end
`endif
                end else if (!hold && t - t_in >= DRN) begin
                    nx = 2'd0;
                    m_boot = bus.boot_sel_i ? 32'h0 : 32'h8000;
                    if (m_rc < 255) m_rc++;
                end
                if (nx != m_st) begin t_in = t; wd_ref = t; end
                m_st = nx;
                m_cg = (nx == 2'd2) && bus.cg_en_i;
            end
        end
    end

    initial forever begin
        logic [46:0] dv, mv;
        @(negedge clk);
        dv = {bus.core_rst_n_o, bus.fetch_enable_o, bus.boot_addr_o, bus.clock_gating_o, bus.testmode_o,
              bus.state_o, bus.restart_cnt_o, bus.wdt_trip_o};
        mv = {m_st != 2'd0, m_st == 2'd2, m_boot, m_cg, 1'b0, m_st, m_rc[7:0], m_trip};
        n_chk++;
        if (dv !== mv) begin
            n_fail++;
            $display("FAIL outputs at edge %0d: dut=%h model=%h", t, dv, mv);
        end
    end

    // Heartbeat on bit HB toggles every 50 edges while hb_run; all other PIO bits are noise.
    initial begin
        int div = 0;
        logic [31:0] r;
        bus.pio_out_i = '0;
        forever begin
            @(posedge clk); #2;
            div++;
            r = $urandom;
            r[HB] = bus.pio_out_i[HB];
            if (hb_run && div >= 50) begin
                div = 0;
                r[HB] = ~r[HB];
`ifdef PULPINO_BOOT_WDT_EN
                t_hb = t + 1;
`endif
            end
            bus.pio_out_i = r;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout at edge %0d", t);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        bus.master_reset_i = 0; bus.halt_req_i = 0; bus.boot_sel_i = 1; bus.cg_en_i = 0; hb_run = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rst_n", bus.core_rst_n_o, 0);
        chk("rst_fetch", bus.fetch_enable_o, 0);
        chk("rst_boot_addr", bus.boot_addr_o, 32'h8000);
        chk("rst_state", bus.state_o, 0);
        chk("rst_restart_cnt", bus.restart_cnt_o, 0);
        @(negedge clk) rst_n = 1;
        wait_edge(15); chk("core_rst_n_e15", bus.core_rst_n_o, 0);
        wait_edge(16); chk("core_rst_n_e16", bus.core_rst_n_o, 1);
        chk("boot_alt", bus.boot_addr_o, 32'h0);
        chk("state_release", bus.state_o, 1);
        wait_edge(19); chk("fetch_e19", bus.fetch_enable_o, 0);
        wait_edge(20); chk("fetch_e20", bus.fetch_enable_o, 1);
        chk("state_run", bus.state_o, 2);
        chk("cg_e20", bus.clock_gating_o, 0);
        bus.cg_en_i = 1;
        wait_edge(21); chk("cg_e21", bus.clock_gating_o, 1);
        // master reset pulse; boot select changes before the re-boot so the reload is visible
        n = t + 1;
        bus.master_reset_i = 1;
        wait_edge(n);
        bus.master_reset_i = 0; bus.boot_sel_i = 0;
        chk("mr_fetch_low", bus.fetch_enable_o, 0);
        chk("mr_state_halt", bus.state_o, 3);
        chk("mr_cg_low", bus.clock_gating_o, 0);
        wait_edge(n + 7);
        chk("drain_core_rst_n", bus.core_rst_n_o, 1);
        chk("drain_boot_stable", bus.boot_addr_o, 32'h0);
        wait_edge(n + 8);
        chk("mr_core_rst_low", bus.core_rst_n_o, 0);
        chk("mr_restart_cnt", bus.restart_cnt_o, 1);
        chk("reboot_boot_rom", bus.boot_addr_o, 32'h8000);
        wait_edge(n + 27); chk("reboot_fetch_e27", bus.fetch_enable_o, 0);
        wait_edge(n + 28); chk("reboot_fetch_e28", bus.fetch_enable_o, 1);
`ifdef PULPINO_BOOT_WDT_EN
        wait_edge(t + 300);
        chk("hb_no_trip_state", bus.state_o, 2);
        hb_run = 0;
        n = 0;
        while (bus.wdt_trip_o !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("wdt_trip_edge", 32'(t), 32'(t_hb + 99));
        chk("wdt_trip_state", bus.state_o, 3);
        @(posedge clk); #1;
        chk("wdt_trip_single", bus.wdt_trip_o, 0);
        hb_run = 1;
        wait_state(2, 200);
        wait_edge(t + 60);
        hb_run = 0;
        wait_edge(t_hb + 98);
        bus.master_reset_i = 1;
        wait_edge(t_hb + 99);
        bus.master_reset_i = 0;
        chk("wdt_mr_no_trip", bus.wdt_trip_o, 0);
        chk("wdt_mr_state", bus.state_o, 3);
        hb_run = 1;
`endif
        // halt request held for 40 edges in RUN, then held for 5 edges in SETUP
        wait_state(2, 200);
        n = t + 1;
        bus.halt_req_i = 1;
        wait_edge(n + 39); chk("halt_hold_e39", bus.state_o, 3);
        bus.halt_req_i = 0;
        wait_edge(n + 40); chk("halt_exit_e40", bus.state_o, 0);
        bus.halt_req_i = 1;
        wait_edge(n + 45);
        bus.halt_req_i = 0;
        wait_edge(n + 60); chk("setup_hold_e60", bus.core_rst_n_o, 0);
        wait_edge(n + 61); chk("setup_hold_e61", bus.core_rst_n_o, 1);
        bus.cg_en_i = 0;
        for (int i = 0; i < 300; i++) begin
            wait_state(1, 100);
            bus.master_reset_i = 1;
            @(posedge clk); #1;
            bus.master_reset_i = 0;
        end
        chk("restart_sat", bus.restart_cnt_o, 255);
        // asynchronous reset in the middle of RELEASE
        wait_state(1, 100);
        #2 rst_n = 0;
        #1;
        chk("async_core_rst_n", bus.core_rst_n_o, 0);
        chk("async_state", bus.state_o, 0);
        chk("async_restart_cnt", bus.restart_cnt_o, 0);
        chk("async_boot_addr", bus.boot_addr_o, 32'h8000);
        chk("async_fetch", bus.fetch_enable_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_edge(0); chk("boot_rom_e0", bus.boot_addr_o, 32'h8000);
        wait_edge(20); chk("fetch_after_reset", bus.fetch_enable_o, 1);
`ifndef PULPINO_BOOT_WDT_EN
        hb_run = 0;
        wait_edge(t + 10 * WDT);
        chk("idle_stays_run", bus.state_o, 2);
        chk("idle_no_trip", bus.wdt_trip_o, 0);
`endif
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pulpino_boot_ctrl.md
# pulpino_boot_ctrl

Boot and run-time sequencer for the PULPino core inside the `sys` Qsys system. It drives the core's configuration conduit (boot address, fetch enable, clock gating, test mode) and the core reset. After system reset it releases the core in a fixed order. During operation it watches a software heartbeat on the PIO output port. On a JTAG master reset request or a heartbeat timeout it stops the core, drains, and re-boots it.

## Interface
Parameters:
- `BOOT_ADDR_ROM`, 32'h0000_8000: boot address when `boot_sel_i`=0.
- `BOOT_ADDR_ALT`, 32'h0000_0000: boot address when `boot_sel_i`=1.
- `RST_CYCLES`, 16: cycles the core reset is held in SETUP (≥1).
- `FETCH_DLY`, 4: cycles between core reset release and fetch enable (≥1).
- `DRAIN_CYCLES`, 8: cycles in HALT before re-entering SETUP (≥1).
- `WDT_CYCLES`, 1000000: heartbeat timeout in RUN cycles (32-bit, ≥2).
- `HB_BIT`, 0: heartbeat bit index into `pio_out_i`.

Ports:
- `clk_clk`, in, 1: system clock.
- `reset_reset_n`, in, 1: asynchronous active-low reset.
- `master_reset_i`, in, 1: JTAG master reset request (`master_0_master_reset_reset`), synchronous to `clk_clk`.
- `halt_req_i`, in, 1: host hold request; keeps the core halted while high.
- `boot_sel_i`, in, 1: boot address select; sampled on SETUP entry.
- `cg_en_i`, in, 1: clock-gating permission.
- `pio_out_i`, in, 32: PIO output export; bit `HB_BIT` is the heartbeat.
- `core_rst_n_o`, out, 1: core reset, active-low.
- `fetch_enable_o`, out, 1: to `pulpino_0_config_fetch_enable_i`.
- `boot_addr_o`, out, 32: to `pulpino_0_config_boot_addr_i`.
- `clock_gating_o`, out, 1: to `pulpino_0_config_clock_gating_i`.
- `testmode_o`, out, 1: to `pulpino_0_config_testmode_i`.
- `state_o`, out, 2: FSM state; SETUP=0, RELEASE=1, RUN=2, HALT=3.
- `restart_cnt_o`, out, 8: count of re-boots.
- `wdt_trip_o`, out, 1: one-cycle pulse on a watchdog-caused halt.

## Operation
- All outputs are registered.
- Reset values:
  - State SETUP; `core_rst_n_o`=0, `fetch_enable_o`=0, `clock_gating_o`=0, `testmode_o`=0 (constant).
  - `boot_addr_o`=`BOOT_ADDR_ROM`, `restart_cnt_o`=0, `wdt_trip_o`=0.
- SETUP:
  - `core_rst_n_o`=0, `fetch_enable_o`=0.
  - `boot_addr_o` is loaded from `boot_sel_i` on entry; after reset it is loaded on the first active edge.
  - Counts `RST_CYCLES` cycles, then goes to RELEASE.
  - If `master_reset_i` or `halt_req_i` is high, the counter is held at 0.
- RELEASE:
  - `core_rst_n_o`=1.
  - Counts `FETCH_DLY` cycles, then goes to RUN.
  - `master_reset_i` goes to HALT.
- RUN:
  - `fetch_enable_o`=1; `clock_gating_o` follows `cg_en_i` with 1-cycle latency.
  - `master_reset_i`=1 or `halt_req_i`=1 goes to HALT.
  - Watchdog timeout goes to HALT with a `wdt_trip_o` pulse.
- HALT:
  - `fetch_enable_o`=0, `clock_gating_o`=0, `core_rst_n_o`=1.
  - Counts `DRAIN_CYCLES` cycles. It stays in HALT while `master_reset_i` or `halt_req_i` is high; otherwise it goes to SETUP.
  - `restart_cnt_o` increments on the HALT→SETUP transition and saturates at 255.
- Watchdog:
  - Heartbeat edge = `pio_out_i[HB_BIT]` differs from its value registered one cycle earlier.
  - The counter clears on RUN entry and on every heartbeat edge, and is frozen outside RUN.
  - Timeout occurs when the counter reaches `WDT_CYCLES`-1 without an edge.
- Priority in the same cycle: `master_reset_i` > `halt_req_i` > timeout. `wdt_trip_o` pulses only when the timeout alone causes the transition. A heartbeat edge in the timeout cycle cancels the timeout.

## Timing
- Edge 0 is the first rising edge with `reset_reset_n` high.
- `core_rst_n_o` rises after edge `RST_CYCLES`.
- `fetch_enable_o` rises after edge `RST_CYCLES`+`FETCH_DLY`.
- A halt trigger sampled at edge N: `fetch_enable_o` falls after edge N, `core_rst_n_o` falls after edge N+`DRAIN_CYCLES`.
- `reset_reset_n` asserted mid-operation forces all outputs to their reset values immediately (asynchronous). `restart_cnt_o` also clears.
- `boot_addr_o` is stable from SETUP entry until the next SETUP entry.

## Configuration
- `PULPINO_BOOT_WDT_EN` defined: heartbeat watchdog, counter and `wdt_trip_o` are built as described.
- Not defined:
  - No watchdog logic is built; `wdt_trip_o` is tied to 0 and `pio_out_i` is ignored.
  - RUN exits only on `master_reset_i` or `halt_req_i`.

## Test plan
- Release `reset_reset_n` with `boot_sel_i`=1 → `boot_addr_o`=0, `core_rst_n_o` high after edge 16, `fetch_enable_o` high after edge 20, `state_o`=2.
- In RUN, pulse `master_reset_i` 1 cycle at edge N → `fetch_enable_o` low after N, `core_rst_n_o` low after N+8, `restart_cnt_o`=1, re-boot completes 20 edges later.
- With `WDT_CYCLES`=100, toggle heartbeat every 50 cycles → no trip. Stop toggling → single `wdt_trip_o` pulse 99 cycles after the last edge, then HALT.
- Hold `halt_req_i` high for 40 cycles in RUN → HALT persists 40 cycles, then SETUP. Timeout and `master_reset_i` in the same cycle → no `wdt_trip_o`.
- Force 300 restarts → `restart_cnt_o` saturates at 255. Assert `reset_reset_n` low mid-RELEASE → all outputs at reset values at once, counter 0.
- Build without `PULPINO_BOOT_WDT_EN`, idle heartbeat for 10× `WDT_CYCLES` → stays in RUN, `wdt_trip_o`=0.
